// File: rtl/branch_resolve_ctrl.sv
// In-flight predicted-branch queue that checks BRU resolutions against the oldest prediction.
// Optional macro BRANCH_STATS_EN builds the resolved/mispredict statistics counters.
module branch_resolve_ctrl #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic                    push_pred_taken,
    input  logic [31:0]             push_pred_pc,
    input  logic                    res_valid,
    input  logic                    res_taken,
    input  logic [31:0]             res_pc,
    output logic                    redirect_valid,
    output logic [31:0]             redirect_pc,
    output logic                    flush,
    output logic                    mispredict,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    err_underflow,
    output logic [31:0]             stat_branches,
    output logic [31:0]             stat_mispred
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(FLUSH_CYC) + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_REDIRECT,
        ST_RECOVER
    } state_e;

    typedef struct packed {
        logic        pred_taken;
        logic [31:0] pred_pc;
    } entry_t;

    entry_t             queue_q [DEPTH];
    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic               flush_q, flush_d;
    logic               err_q, err_d;

    entry_t             head;
    logic               in_run;
    logic               do_resolve;
    logic               do_mis;
    logic               do_pop;
    logic               do_push;

    // Resolution compare against the head entry and push/pop qualification.
    always_comb begin
        in_run     = (state_q == ST_RUN);
        head       = queue_q[rd_ptr_q];
        do_resolve = in_run & res_valid & (occ_q != '0);
        do_mis     = do_resolve & ((res_taken != head.pred_taken) | (res_pc != head.pred_pc));
        do_pop     = do_resolve & ~do_mis;
        push_ready = in_run & ((occ_q < OCC_W'(DEPTH)) | res_valid);
        // A push alongside a mispredict is on the wrong path and is dropped.
        do_push    = push_valid & push_ready & ~do_mis;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        flush_d          = 1'b0;
        redirect_valid_d = do_mis;
        redirect_pc_d    = redirect_pc_q;
        err_d            = err_q | (in_run & res_valid & (occ_q == '0));
        occ_d            = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
        rd_ptr_d         = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d         = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

        case (state_q)
            ST_RUN: begin
                if (do_mis) begin
                    state_d       = ST_REDIRECT;
                    flush_d       = 1'b1;
                    cnt_d         = CNT_W'(FLUSH_CYC - 1);
                    redirect_pc_d = res_pc;
                    occ_d         = '0;
                    rd_ptr_d      = '0;
                    wr_ptr_d      = '0;
                end
            end
            ST_REDIRECT: begin
                if (FLUSH_CYC > 1) begin
                    state_d = ST_RECOVER;
                    flush_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RECOVER: begin
                // cnt_q holds the flush cycles still owed including this one.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_RUN;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            occ_q            <= '0;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            err_q            <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                queue_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            occ_q            <= occ_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            err_q            <= err_d;
            if (do_push) begin
                queue_q[wr_ptr_q] <= '{pred_taken: push_pred_taken, pred_pc: push_pred_pc};
            end
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign mispredict     = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign occupancy      = occ_q;
    assign err_underflow  = err_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    // Saturating event counters.
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (do_resolve && (stat_br_q != '1)) begin
            stat_br_d = stat_br_q + 32'd1;
        end
        if (do_mis && (stat_mp_q != '1)) begin
            stat_mp_d = stat_mp_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches = stat_br_q;
    assign stat_mispred  = stat_mp_q;
`else
    assign stat_branches = 32'h0;
    assign stat_mispred  = 32'h0;
`endif

endmodule
